// File: rtl/snes_multi_pad.sv
// SNES controller poller: drives shared LATCH/PULSE to up to four pads, shifts in
// their serial buttons and reports per-frame state plus press/release edges.
module snes_multi_pad #(
  parameter int NUM_PADS  = 2,
  parameter int NUM_BITS  = 12,
  parameter int HALF      = 300,
  parameter int AUTO_POLL = 1,
  parameter int POLL_DIV  = 833333
) (
  input  logic                         CLOCK,
  input  logic                         RESET_N,
  input  logic                         START,
  input  logic [NUM_PADS-1:0]          DATA,
  output logic                         LATCH,
  output logic                         PULSE,
  output logic [NUM_PADS*NUM_BITS-1:0] BUTTONS,
  output logic [NUM_PADS*NUM_BITS-1:0] PRESSED,
  output logic [NUM_PADS*NUM_BITS-1:0] RELEASED,
  output logic                         VALID,
  output logic                         BUSY
);

  localparam int W  = NUM_PADS * NUM_BITS;
  localparam int CW = $clog2(2 * HALF);
  localparam int IW = $clog2(NUM_BITS + 1);
  localparam int PW = $clog2(POLL_DIV);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_PLOW, S_PHIGH, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        poll_q, poll_d;
  logic [W-1:0]         samp_q, samp_d;
  logic [NUM_PADS-1:0]  sync1_q, sync2_q;
  logic                 latch_q, pulse_q, valid_q;
  logic [W-1:0]         buttons_q, buttons_d, pressed_q, pressed_d, released_q, released_d;
  logic                 poll_wrap, trig, sample_en;

  assign poll_wrap = (poll_q == PW'(POLL_DIV - 1));
  assign poll_d    = poll_wrap ? '0 : poll_q + PW'(1);
  assign trig      = START || ((AUTO_POLL != 0) && poll_wrap);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    sample_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (trig) begin
          state_d = S_LATCH;
          idx_d   = '0;
        end
      end
      S_LATCH: begin
        if (cnt_q == CW'(2 * HALF - 1)) begin
          sample_en = 1'b1;
          cnt_d     = '0;
          if (NUM_BITS == 1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PLOW;
            idx_d   = IW'(1);
          end
        end
      end
      S_PLOW: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = S_PHIGH;
        end
      end
      S_PHIGH: begin
        if (cnt_q == CW'(HALF - 1)) begin
          sample_en = 1'b1;
          cnt_d     = '0;
          if (idx_q == IW'(NUM_BITS - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PLOW;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only the bit at the current index is captured; other sample bits hold.
  always_comb begin
    samp_d = samp_q;
    if (sample_en) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        for (int unsigned b = 0; b < NUM_BITS; b++) begin
          if (idx_q == IW'(b)) samp_d[p*NUM_BITS + b] = sync2_q[p];
        end
      end
    end
  end

  always_comb begin
    buttons_d  = buttons_q;
    pressed_d  = '0;
    released_d = '0;
    if (state_q == S_DONE) begin
      buttons_d  = ~samp_q;
      pressed_d  = ~samp_q & ~buttons_q;
      released_d = samp_q & buttons_q;
    end
  end

  // LATCH/PULSE are registered from the next state so they align with state_q.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      poll_q     <= '0;
      samp_q     <= '1;
      sync1_q    <= '1;
      sync2_q    <= '1;
      latch_q    <= 1'b0;
      pulse_q    <= 1'b1;
      valid_q    <= 1'b0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      poll_q     <= poll_d;
      samp_q     <= samp_d;
      sync1_q    <= DATA;
      sync2_q    <= sync1_q;
      latch_q    <= (state_d == S_LATCH);
      pulse_q    <= (state_d != S_PLOW);
      valid_q    <= (state_q == S_DONE);
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign LATCH    = latch_q;
  assign PULSE    = pulse_q;
  assign VALID    = valid_q;
  assign BUTTONS  = buttons_q;
  assign PRESSED  = pressed_q;
  assign RELEASED = released_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_snes_multi_pad.sv
// Bench for snes_multi_pad: behavioural pad shift-register model, frame scoreboard,
// timing/decode/edge/abuse checks plus an auto-poll instance.
module tb_snes_multi_pad;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  DATA;
  logic        LATCH, PULSE, VALID, BUSY;
  logic [23:0] BUTTONS, PRESSED, RELEASED;

  logic        rst_ap_n = 1'b0;
  logic [1:0]  data_ap = 2'b11;
  logic        start_ap = 1'b0;
  logic        latch_ap, pulse_ap, valid_ap, busy_ap;
  logic [23:0] buttons_ap, pressed_ap, released_ap;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [23:0] b; logic [23:0] pr; logic [23:0] rl; } exp_t;
  exp_t        sb[$];
  int          ap_q[$];
  logic [23:0] model_buttons = '0;
  logic [11:0] pad_press [2];

  always #5 CLOCK = ~CLOCK;

  snes_multi_pad #(.NUM_PADS(2), .NUM_BITS(12), .HALF(4), .AUTO_POLL(0), .POLL_DIV(1000)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .DATA(DATA),
    .LATCH(LATCH), .PULSE(PULSE), .BUTTONS(BUTTONS), .PRESSED(PRESSED),
    .RELEASED(RELEASED), .VALID(VALID), .BUSY(BUSY));

  snes_multi_pad #(.NUM_PADS(2), .NUM_BITS(12), .HALF(4), .AUTO_POLL(1), .POLL_DIV(200)) dut_ap (
    .CLOCK(CLOCK), .RESET_N(rst_ap_n), .START(start_ap), .DATA(data_ap),
    .LATCH(latch_ap), .PULSE(pulse_ap), .BUTTONS(buttons_ap), .PRESSED(pressed_ap),
    .RELEASED(released_ap), .VALID(valid_ap), .BUSY(busy_ap));

  // Pad model: LATCH reloads to bit 0, each PULSE rising edge shifts to the next bit.
  initial begin
    int   pidx;
    logic prev_p;
    pidx = 12; prev_p = 1'b1;
    pad_press[0] = '0; pad_press[1] = '0;
    DATA = 2'b11;
    forever begin
      @(negedge CLOCK);
      if (LATCH) pidx = 0;
      else if (PULSE && !prev_p && pidx < 12) pidx++;
      prev_p = PULSE;
      if (pidx < 12) DATA = {~pad_press[1][pidx], ~pad_press[0][pidx]};
      else DATA = 2'b11;
    end
  end

  function automatic void push_expected(input logic [11:0] p0, input logic [11:0] p1);
    exp_t e;
    logic [23:0] nw;
    nw   = {p1, p0};
    e.b  = nw;
    e.pr = nw & ~model_buttons;
    e.rl = ~nw & model_buttons;
    model_buttons = nw;
    sb.push_back(e);
  endfunction

  task automatic run_frame(input logic [11:0] p0, input logic [11:0] p1, input bit mid_start,
                           output int n, output int lat, output int plo, output int falls,
                           output logic [23:0] b, output logic [23:0] pr, output logic [23:0] rl,
                           output logic busy_mid, output logic busy_v,
                           output logic v_after, output logic [23:0] edge_after);
    logic prev_p;
    n = 0; lat = 0; plo = 0; falls = 0;
    b = 'x; pr = 'x; rl = 'x; busy_mid = 1'b0; busy_v = 1'b1;
    pad_press[0] = p0; pad_press[1] = p1;
    @(negedge CLOCK);
    START = 1'b1;
    prev_p = PULSE;
    for (int k = 1; k <= 300; k++) begin
      @(posedge CLOCK); @(negedge CLOCK);
      if (k == 1) START = 1'b0;
      if (mid_start && k == 40) START = 1'b1;
      if (mid_start && k == 41) START = 1'b0;
      if (k == 2) busy_mid = BUSY;
      if (LATCH) lat++;
      if (!PULSE) plo++;
      if (prev_p && !PULSE) falls++;
      prev_p = PULSE;
      if (VALID) begin
        n = k; b = BUTTONS; pr = PRESSED; rl = RELEASED; busy_v = BUSY;
        break;
      end
    end
    @(negedge CLOCK);
    v_after    = VALID;
    edge_after = PRESSED | RELEASED;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLOCK);
    if (LATCH !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b want 0", LATCH); end
    checks++;
    if (PULSE !== 1'b1) begin errors++; $display("FAIL reset_pulse: got %b want 1", PULSE); end
    checks++;
    if (BUTTONS !== 24'h0) begin errors++; $display("FAIL reset_buttons: got %h want 0", BUTTONS); end
    checks++;
    if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", VALID); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++;
    RESET_N = 1'b1;
    model_buttons = '0;
    repeat (3) @(negedge CLOCK);
  endtask

  task automatic test_timing();
    int n, lat, plo, falls;
    logic [23:0] b, pr, rl, ea;
    logic bm, bv, va;
    exp_t e;
    push_expected(12'h000, 12'h000);
    run_frame(12'h000, 12'h000, 1'b0, n, lat, plo, falls, b, pr, rl, bm, bv, va, ea);
    e = sb.pop_front();
    if (n !== 98) begin errors++; $display("FAIL timing_valid_latency: got %0d want 98", n); end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL timing_latch_cycles: got %0d want 8", lat); end
    checks++;
    if (plo !== 44) begin errors++; $display("FAIL timing_pulse_low_cycles: got %0d want 44", plo); end
    checks++;
    if (falls !== 11) begin errors++; $display("FAIL timing_pulse_phases: got %0d want 11", falls); end
    checks++;
    if (bm !== 1'b1) begin errors++; $display("FAIL timing_busy_mid: got %b want 1", bm); end
    checks++;
    if (bv !== 1'b0) begin errors++; $display("FAIL timing_busy_after: got %b want 0", bv); end
    checks++;
    if (va !== 1'b0) begin errors++; $display("FAIL timing_valid_width: got %b want 0", va); end
    checks++;
    if (b !== e.b) begin errors++; $display("FAIL timing_buttons: got %h want %h", b, e.b); end
    checks++;
  endtask

  task automatic test_decode();
    int n, lat, plo, falls;
    logic [23:0] b, pr, rl, ea;
    logic bm, bv, va;
    exp_t e;
    push_expected(12'h008, 12'h801);
    run_frame(12'h008, 12'h801, 1'b0, n, lat, plo, falls, b, pr, rl, bm, bv, va, ea);
    e = sb.pop_front();
    if (n !== 98) begin errors++; $display("FAIL decode_latency: got %0d want 98", n); end
    checks++;
    if (b !== e.b) begin errors++; $display("FAIL decode_buttons: got %h want %h", b, e.b); end
    checks++;
    if (pr !== e.pr) begin errors++; $display("FAIL decode_pressed: got %h want %h", pr, e.pr); end
    checks++;
    if (rl !== e.rl) begin errors++; $display("FAIL decode_released: got %h want %h", rl, e.rl); end
    checks++;
    if (ea !== 24'h0) begin errors++; $display("FAIL decode_edge_width: got %h want 0", ea); end
    checks++;
  endtask

  task automatic test_edges();
    int n, lat, plo, falls;
    logic [23:0] b, pr, rl, ea;
    logic bm, bv, va;
    exp_t e;
    push_expected(12'h008, 12'h801);
    run_frame(12'h008, 12'h801, 1'b0, n, lat, plo, falls, b, pr, rl, bm, bv, va, ea);
    e = sb.pop_front();
    if (b !== e.b) begin errors++; $display("FAIL repeat_buttons: got %h want %h", b, e.b); end
    checks++;
    if (pr !== e.pr) begin errors++; $display("FAIL repeat_pressed: got %h want %h", pr, e.pr); end
    checks++;
    if (rl !== e.rl) begin errors++; $display("FAIL repeat_released: got %h want %h", rl, e.rl); end
    checks++;
    push_expected(12'h000, 12'h801);
    run_frame(12'h000, 12'h801, 1'b0, n, lat, plo, falls, b, pr, rl, bm, bv, va, ea);
    e = sb.pop_front();
    if (b !== e.b) begin errors++; $display("FAIL release_buttons: got %h want %h", b, e.b); end
    checks++;
    if (rl !== e.rl) begin errors++; $display("FAIL release_released: got %h want %h", rl, e.rl); end
    checks++;
    if (pr !== e.pr) begin errors++; $display("FAIL release_pressed: got %h want %h", pr, e.pr); end
    checks++;
    if (ea !== 24'h0) begin errors++; $display("FAIL release_edge_width: got %h want 0", ea); end
    checks++;
  endtask

  task automatic test_abuse();
    int n, lat, plo, falls, vcnt;
    logic [23:0] b, pr, rl, ea;
    logic bm, bv, va;
    exp_t e;
    push_expected(12'h00f, 12'h000);
    run_frame(12'h00f, 12'h000, 1'b1, n, lat, plo, falls, b, pr, rl, bm, bv, va, ea);
    e = sb.pop_front();
    if (n !== 98) begin errors++; $display("FAIL midstart_latency: got %0d want 98", n); end
    checks++;
    if (b !== e.b) begin errors++; $display("FAIL midstart_buttons: got %h want %h", b, e.b); end
    checks++;
    vcnt = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge CLOCK);
      if (VALID || BUSY) vcnt++;
    end
    if (vcnt !== 0) begin errors++; $display("FAIL midstart_no_second_frame: got %0d want 0", vcnt); end
    checks++;

    // Reset asserted while PULSE is low inside the frame.
    pad_press[0] = 12'hfff; pad_press[1] = 12'hfff;
    @(negedge CLOCK);
    START = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      @(posedge CLOCK); @(negedge CLOCK);
      if (k == 1) START = 1'b0;
    end
    if (PULSE !== 1'b0) begin errors++; $display("FAIL abort_pre_pulse: got %b want 0", PULSE); end
    checks++;
    RESET_N = 1'b0;
    #1;
    if (LATCH !== 1'b0) begin errors++; $display("FAIL abort_latch: got %b want 0", LATCH); end
    checks++;
    if (PULSE !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b want 1", PULSE); end
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", BUSY); end
    checks++;
    if (BUTTONS !== 24'h0) begin errors++; $display("FAIL abort_buttons: got %h want 0", BUTTONS); end
    checks++;
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    model_buttons = '0;
    vcnt = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge CLOCK);
      if (VALID) vcnt++;
    end
    if (vcnt !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d want 0", vcnt); end
    checks++;
    if (BUTTONS !== 24'h0) begin errors++; $display("FAIL abort_buttons_hold: got %h want 0", BUTTONS); end
    checks++;
  endtask

  task automatic test_autopoll();
    int seen[$];
    logic [23:0] bsum;
    int exp_c, got_c;
    ap_q.push_back(297); ap_q.push_back(497); ap_q.push_back(697);
    bsum = '0;
    @(negedge CLOCK);
    rst_ap_n = 1'b1;
    for (int k = 1; k <= 760; k++) begin
      @(posedge CLOCK); @(negedge CLOCK);
      if (valid_ap) begin
        seen.push_back(k);
        bsum = bsum | buttons_ap | pressed_ap | released_ap;
      end
    end
    while (ap_q.size() > 0) begin
      exp_c = ap_q.pop_front();
      got_c = (seen.size() > 0) ? seen.pop_front() : -1;
      if (got_c !== exp_c) begin errors++; $display("FAIL autopoll_valid_cycle: got %0d want %0d", got_c, exp_c); end
      checks++;
    end
    if (seen.size() !== 0) begin errors++; $display("FAIL autopoll_extra_valid: got %0d want 0", seen.size()); end
    checks++;
    if (bsum !== 24'h0) begin errors++; $display("FAIL autopoll_absent_pads: got %h want 0", bsum); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_decode();
    test_edges();
    test_abuse();
    test_autopoll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snes_multi_pad.md
SNES_MULTI_PAD -- requirements
Module: snes_multi_pad

Interface
REQ-001 Parameter NUM_PADS, default 2: number of controllers sharing LATCH/PULSE (1..4).
REQ-002 Parameter NUM_BITS, default 12: serial bits read per pad per frame (2..16).
REQ-003 Parameter HALF, default 300: cycles per LATCH half-width and per PULSE phase (300 = 6 us at 50 MHz); HALF >= 4.
REQ-004 Parameter AUTO_POLL, default 1: 1 = self-triggered polling, 0 = START-triggered only.
REQ-005 Parameter POLL_DIV, default 833333: cycles between auto-poll triggers (60 Hz at 50 MHz); POLL_DIV > 2*HALF*NUM_BITS+2.
REQ-006 CLOCK  in  1  system clock; the block's only clock.
REQ-007 RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-008 START  in  1  one-cycle poll request, honoured in IDLE only.
REQ-009 DATA  in  NUM_PADS  serial data from each pad, active-low (0 = pressed), asynchronous.
REQ-010 LATCH  out  1  latch strobe to all pads, active-high.
REQ-011 PULSE  out  1  shift clock to all pads, idles high.
REQ-012 BUTTONS  out  NUM_PADS*NUM_BITS  debounced-by-frame state, active-high; pad p at [p*NUM_BITS +: NUM_BITS], bit 0 = first bit read.
REQ-013 PRESSED  out  NUM_PADS*NUM_BITS  one-cycle pulse per button transitioning 0->1.
REQ-014 RELEASED  out  NUM_PADS*NUM_BITS  one-cycle pulse per button transitioning 1->0.
REQ-015 VALID  out  1  one-cycle strobe when BUTTONS/PRESSED/RELEASED update.
REQ-016 BUSY  out  1  high while a frame is in progress (state not IDLE).

Function
REQ-017 Each DATA bit SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-018 FSM states SHALL be IDLE, LATCH, PLOW, PHIGH, DONE.
REQ-019 Trigger = START, or (AUTO_POLL=1 and poll counter == POLL_DIV-1); poll counter free-runs 0..POLL_DIV-1 and wraps.
REQ-020 IDLE: on trigger -> LATCH; LATCH=0, PULSE=1.
REQ-021 LATCH: LATCH=1 for exactly 2*HALF cycles; bit 0 of every pad sampled on the last LATCH cycle; then -> PLOW with bit index 1, or -> DONE if NUM_BITS=1.
REQ-022 PLOW: PULSE=0 for exactly HALF cycles -> PHIGH.
REQ-023 PHIGH: PULSE=1 for exactly HALF cycles; current bit index of every pad sampled on the last PHIGH cycle; if index == NUM_BITS-1 -> DONE, else index+1 -> PLOW.
REQ-024 Exactly NUM_BITS-1 PULSE low phases SHALL occur per frame.
REQ-025 DONE (1 cycle): new = ~sampled bits; BUTTONS<=new, PRESSED<=new&~BUTTONS, RELEASED<=~new&BUTTONS, VALID<=1; -> IDLE.
REQ-026 VALID, PRESSED, RELEASED SHALL be high for exactly one cycle, the cycle after DONE; zero otherwise.
REQ-027 VALID SHALL assert exactly 2*HALF*NUM_BITS+2 cycles after the cycle the trigger is sampled in IDLE (97+1 = 98 for HALF=4, NUM_BITS=12).
REQ-028 Triggers outside IDLE (START or poll wrap) SHALL be ignored, not queued.
REQ-029 Simultaneous START and poll wrap in IDLE SHALL start a single frame.
REQ-030 A pad held at DATA=1 (absent/pulled up) SHALL read as all buttons released.
REQ-031 LATCH and PULSE SHALL be registered outputs, glitch-free.

Reset
REQ-032 RESET_N low SHALL immediately force: state IDLE, LATCH=0, PULSE=1, BUTTONS=0, PRESSED=0, RELEASED=0, VALID=0, BUSY=0, poll counter 0, bit index 0, sample registers all 1, synchronizers all 1.
REQ-033 Reset mid-frame SHALL abort the frame without asserting VALID; BUTTONS stays 0 until the next complete frame.

Verification (NUM_PADS=2, NUM_BITS=12, HALF=4, AUTO_POLL=0 unless stated)
REQ-034 Reset check: hold RESET_N=0 -> LATCH=0, PULSE=1, BUTTONS=0, VALID=0, BUSY=0.
REQ-035 Timing: single START -> LATCH high 8 cycles, 11 PULSE lows of 4 cycles each, VALID 98 cycles after START sampled, BUSY low afterwards.
REQ-036 Decode: pad0 drives 0 only during bit 3, pad1 drives 0 during bits 0 and 11 -> BUTTONS = {12'h801, 12'h008}, PRESSED equal to BUTTONS for one cycle, RELEASED=0.
REQ-037 Edges: repeat same frame -> PRESSED=0; then pad0 all-1 -> BUTTONS[11:0]=0, RELEASED[3]=1 for one cycle.
REQ-038 Abuse: START pulsed mid-frame -> no second frame; RESET_N low at cycle 40 of a frame -> LATCH=0, PULSE=1 same cycle, no VALID.
REQ-039 Auto-poll: AUTO_POLL=1, POLL_DIV=200, START tied 0 -> VALID strobes every 200 cycles, first frame starting at cycle 199 after reset release.
